// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: 32-step shift-add multiply or restoring divide.
// Latency: done in cycle 35 after accepted start (2 for divide special cases); start ignored while busy.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                is_div, a_neg, b_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       sum, diff;
  logic [2*XLEN-1:0]   sh, prod;
  logic [XLEN-1:0]     quo, rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    is_div = op_q[2];
    a_neg  = a_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_MULHSU ||
                             op_q == OP_DIV  || op_q == OP_REM);
    b_neg  = b_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
    mag_a  = a_neg ? -a_q : a_q;
    mag_b  = b_neg ? -b_q : b_q;

    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    sh   = {acc_q[2*XLEN-2:0], 1'b0};
    diff = {1'b0, sh[2*XLEN-1:XLEN]} - {1'b0, opnd_q};

    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // Remainder takes the dividend's sign; everything else the xor of operand signs.
        neg_d = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
        if (is_div && b_q == '0) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = S_DONE;
        end else if ((op_q == OP_DIV || op_q == OP_REM) &&
                     a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
          result_d = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          state_d  = S_DONE;
        end else begin
          opnd_d  = is_div ? mag_b : mag_a;
          acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (is_div) begin
          acc_d = diff[XLEN] ? sh : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
        end else begin
          acc_d = {sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          OP_MUL:                     result_d = acc_q[XLEN-1:0];
          3'b001, 3'b010, 3'b011:     result_d = prod[2*XLEN-1:XLEN];
          3'b100, 3'b101:             result_d = quo;
          default:                    result_d = rem;
        endcase
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A kill leaves the previous result visible.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: table of operations plus flush/reset/busy-start sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res;

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; the next posedge accepts the start.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e, input int lat);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5a5a_a5a5;
    n = 1;
    check({nm, "_busy_c1"}, {31'b0, busy}, 32'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, lat);
    check({nm, "_result"}, result, e);
    @(negedge clk);
    check({nm, "_after_done"}, {30'b0, busy, done}, 32'd0);
    last_res = e;
  endtask

  initial begin
    vecs[0]  = '{"mul_neg",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
    vecs[1]  = '{"mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
    vecs[2]  = '{"mulhu_min",   3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
    vecs[3]  = '{"mulhsu_min",  3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 35};
    vecs[4]  = '{"div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 35};
    vecs[5]  = '{"rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 35};
    vecs[6]  = '{"divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,        35};
    vecs[7]  = '{"remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,         35};
    vecs[8]  = '{"divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 2};
    vecs[9]  = '{"rem_by0",     3'b110, 32'd5,        32'd0,        32'd5,         2};
    vecs[10] = '{"div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{"rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2};
    vecs[12] = '{"mulhu_ones",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
    vecs[13] = '{"mulh_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         35};
    vecs[14] = '{"mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 35};
    vecs[15] = '{"div_20_m3",   3'b100, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 35};
    vecs[16] = '{"rem_20_m3",   3'b110, 32'd20,       32'hFFFF_FFFD, 32'd2,         35};
    vecs[17] = '{"divu_big",    3'b101, 32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, 35};

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    last_res = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, 30'b0} | result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // flush beats start while idle
    begin
      op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_idle_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("flush_start_idle_result", result, last_res);
    end

    // flush in cycle 10 of a DIV, then an immediate MUL
    begin
      op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 2; c <= 10; c++) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_done", {30'b0, busy, done}, 32'd0);
      check("flush_result_kept", result, last_res);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 35);
    end

    // start pulses while busy are ignored
    begin
      int ndone, dcyc;
      ndone = 0; dcyc = 0;
      op = 3'b000; a = 32'h1111; b = 32'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; op = 3'b101; a = 32'd50; b = 32'd5;
      for (int c = 1; c <= 45; c++) begin
        if (c > 1) @(negedge clk);
        if (done) begin
          ndone++;
          dcyc = c;
        end
        start = (c == 5 || c == 20);
      end
      start = 1'b0;
      check("busy_start_done_count", ndone, 32'd1);
      check("busy_start_done_cycle", dcyc, 32'd35);
      check("busy_start_result", result, 32'h3333);
      check("busy_start_idle_end", {31'b0, busy}, 32'd0);
      last_res = 32'h3333;
    end

    // synchronous reset mid-operation
    begin
      int ndone;
      ndone = 0;
      op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 2; c <= 15; c++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy_done", {30'b0, busy, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("midreset_no_done", ndone, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
